// File: rtl/vthernet_pkg.sv
// Shared Vthernet MAC definitions: TX state encoding, framing bytes, CRC-32 constants
// and a byte-wide reflected CRC-32 step used by the TX and RX datapaths.
package vthernet_pkg;

  localparam int unsigned LEN_W = 11;

  localparam int unsigned DEF_MIN_FRAME = 60;
  localparam int unsigned DEF_MAX_LEN   = 1514;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StSfd,
    StData,
    StPad,
    StFcs,
    StIfg
  } tx_state_e;

  // One byte of IEEE 802.3 CRC, bits consumed LSB first.
  function automatic logic [31:0] crc32_step8(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ (CRC_POLY_REFL & {32{c[0] ^ data[i]}});
    end
    return c;
  endfunction

endpackage

// File: rtl/tx_vthernet_mac_if.sv
// TX MAC bus bundle: control/status, TX buffer read port and GMII TX pins.
// master = buffer/control side, slave = the MAC.
interface tx_vthernet_mac_if;
  import vthernet_pkg::*;

  logic             tx_start;
  logic [LEN_W-1:0] tx_len;
  logic             tx_busy;
  logic             tx_done;
  logic             tx_rd_en;
  logic [LEN_W-1:0] tx_addr;
  logic [7:0]       tx_mem_out;
  logic             TX_EN;
  logic [7:0]       TXD;
  logic             TX_ER;

  modport master (
    output tx_start, tx_len, tx_mem_out,
    input  tx_busy, tx_done, tx_rd_en, tx_addr, TX_EN, TXD, TX_ER
  );

  modport slave (
    input  tx_start, tx_len, tx_mem_out,
    output tx_busy, tx_done, tx_rd_en, tx_addr, TX_EN, TXD, TX_ER
  );
endinterface

// File: rtl/crc32_d8.sv
// Byte-wide CRC-32 register: init has priority over enable; register holds otherwise.
module crc32_d8
  import vthernet_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q, crc_d;

  // Next-CRC selection.
  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = CRC_INIT;
    end else if (en_i) begin
      crc_d = crc32_step8(crc_q, data_i);
    end
  end

  // CRC state register, synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/tx_vthernet_mac.sv
// GMII transmit MAC. state_q/cnt_q describe the byte currently on TXD; every pin is
// loaded from next-state values so TXD/TX_EN change exactly on the state edge.
module tx_vthernet_mac
  import vthernet_pkg::*;
#(
  parameter int unsigned IFG_CYCLES   = 12,
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned MIN_FRAME    = DEF_MIN_FRAME,
  parameter int unsigned MAX_LEN      = DEF_MAX_LEN
) (
  input logic               wb_clk_i,
  input logic               rst_n,
  tx_vthernet_mac_if.slave  mac_if
);

  localparam logic [LEN_W-1:0] PreLast   = LEN_W'(PREAMBLE_LEN - 1);
  localparam logic [LEN_W-1:0] MinFrameL = LEN_W'(MIN_FRAME);
  localparam logic [LEN_W-1:0] MaxLenL   = LEN_W'(MAX_LEN);
  // Last IFG state cycle; the final idle cycle is spent in StIdle with tx_done high.
  localparam logic [LEN_W-1:0] IfgLast   = LEN_W'(IFG_CYCLES - 2);

  tx_state_e        state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       txd_q, txd_d;
  logic             txen_q, txen_d;
  logic             done_q, done_d;
  logic             rd_en_q, rd_en_d;
  logic [LEN_W-1:0] addr_q, addr_d;

  logic             crc_init, crc_en;
  logic [7:0]       crc_byte;
  logic [31:0]      crc_q;
  logic             len_ok;
  logic [1:0]       fcs_idx;

  crc32_d8 u_crc (
    .clk_i  (wb_clk_i),
    .rst_ni (rst_n),
    .init_i (crc_init),
    .en_i   (crc_en),
    .data_i (crc_byte),
    .crc_o  (crc_q)
  );

  // Next-state, next-pin values and CRC feed.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    txd_d    = txd_q;
    txen_d   = txen_q;
    done_d   = 1'b0;
    rd_en_d  = rd_en_q;
    addr_d   = addr_q;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    crc_byte = 8'h00;
    fcs_idx  = 2'd0;
    len_ok   = (mac_if.tx_len != '0) && (mac_if.tx_len <= MaxLenL);

    unique case (state_q)
      StIdle: begin
        txen_d = 1'b0;
        txd_d  = 8'h00;
        if (mac_if.tx_start && len_ok) begin
          state_d  = StPreamble;
          cnt_d    = '0;
          len_d    = mac_if.tx_len;
          crc_init = 1'b1;
          txen_d   = 1'b1;
          txd_d    = PREAMBLE_BYTE;
        end
      end
      StPreamble: begin
        txd_d = PREAMBLE_BYTE;
        if (cnt_q == PreLast) begin
          state_d = StSfd;
          txd_d   = SFD_BYTE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSfd: begin
        state_d  = StData;
        cnt_d    = '0;
        txd_d    = mac_if.tx_mem_out;
        crc_en   = 1'b1;
        crc_byte = mac_if.tx_mem_out;
      end
      StData, StPad: begin
        if (cnt_q + 1'b1 < len_q) begin
          state_d  = StData;
          cnt_d    = cnt_q + 1'b1;
          txd_d    = mac_if.tx_mem_out;
          crc_en   = 1'b1;
          crc_byte = mac_if.tx_mem_out;
        end else if (cnt_q + 1'b1 < MinFrameL) begin
          state_d  = StPad;
          cnt_d    = cnt_q + 1'b1;
          txd_d    = 8'h00;
          crc_en   = 1'b1;
          crc_byte = 8'h00;
        end else begin
          // crc_q already includes the byte currently on TXD.
          state_d = StFcs;
          cnt_d   = '0;
          txd_d   = ~crc_q[7:0];
        end
      end
      StFcs: begin
        if (cnt_q[1:0] == 2'd3) begin
          state_d = StIfg;
          cnt_d   = '0;
          txen_d  = 1'b0;
          txd_d   = 8'h00;
        end else begin
          fcs_idx = cnt_q[1:0] + 2'd1;
          cnt_d   = cnt_q + 1'b1;
          txd_d   = ~crc_q[{fcs_idx, 3'b000} +: 8];
        end
      end
      StIfg: begin
        txen_d = 1'b0;
        txd_d  = 8'h00;
        if (cnt_q == IfgLast) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        txen_d  = 1'b0;
        txd_d   = 8'h00;
      end
    endcase

    // Buffer prefetch: reads start two cycles ahead of the first data byte on TXD.
    if (rd_en_q) begin
      if (addr_q + 1'b1 < len_q) begin
        addr_d = addr_q + 1'b1;
      end else begin
        rd_en_d = 1'b0;
      end
    end else if (state_d == StPreamble && cnt_d == PreLast) begin
      rd_en_d = 1'b1;
      addr_d  = '0;
    end
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      txd_q   <= 8'h00;
      txen_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      txd_q   <= txd_d;
      txen_q  <= txen_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
    end
  end

  assign mac_if.tx_busy  = (state_q != StIdle);
  assign mac_if.tx_done  = done_q;
  assign mac_if.tx_rd_en = rd_en_q;
  assign mac_if.tx_addr  = addr_q;
  assign mac_if.TX_EN    = txen_q;
  assign mac_if.TXD      = txd_q;
  assign mac_if.TX_ER    = 1'b0;

endmodule

// File: tb/tb_tx_vthernet_mac.sv
// Bench for tx_vthernet_mac: SRAM model, GMII byte capture and an expected-byte queue
// filled when each frame is launched and drained when the captured frame is scored.
module tb_tx_vthernet_mac;
  import vthernet_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tx_vthernet_mac_if bus ();

  tx_vthernet_mac dut (
    .wb_clk_i (clk),
    .rst_n    (rst_n),
    .mac_if   (bus)
  );

  logic        c_init = 1'b0;
  logic        c_en = 1'b0;
  logic [7:0]  c_data = 8'h00;
  logic [31:0] c_crc;

  crc32_d8 u_crc_unit (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .init_i (c_init),
    .en_i   (c_en),
    .data_i (c_data),
    .crc_o  (c_crc)
  );

  logic [7:0] mem [0:2047];

  // TX buffer SRAM: one-cycle read latency.
  always @(posedge clk) begin
    if (!rst_n) bus.tx_mem_out <= 8'h00;
    else if (bus.tx_rd_en) bus.tx_mem_out <= mem[bus.tx_addr];
  end

  int checks = 0;
  int failures = 0;

  logic [7:0] cap_q [$];
  logic [7:0] exp_q [$];
  int rise_q [$];
  int rd_rise_q [$];
  int en_cnt = 0, rd_cnt = 0, busy_cnt = 0, done_cnt = 0, er_cnt = 0;
  int last_en_cyc = 0, done_cyc = 0, gap = 0;
  bit prev_en = 1'b0, prev_rd = 1'b0;
  int start_cyc = 0;

  // Pin monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.TX_EN) begin
      cap_q.push_back(bus.TXD);
      en_cnt++;
      if (!prev_en) begin
        rise_q.push_back(cyc);
        gap = cyc - last_en_cyc - 1;
      end
      last_en_cyc = cyc;
    end
    if (bus.tx_rd_en) begin
      rd_cnt++;
      if (!prev_rd) rd_rise_q.push_back(cyc);
    end
    if (bus.tx_busy) busy_cnt++;
    if (bus.tx_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.TX_ER) er_cnt++;
    prev_en = bus.TX_EN;
    prev_rd = bus.tx_rd_en;
  end

  function automatic logic [31:0] ref_crc(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int b = 0; b < 8; b++) begin
      if ((c[0] ^ d[b]) == 1'b1) c = (c >> 1) ^ 32'hEDB88320;
      else c = c >> 1;
    end
    return c;
  endfunction

  // Scoreboard push: preamble, SFD, data+pad, FCS of the frame about to be sent.
  task automatic push_expected(input int len);
    logic [31:0] c;
    logic [7:0]  b;
    int          body;
    c = 32'hFFFFFFFF;
    body = (len < 60) ? 60 : len;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < body; i++) begin
      b = (i < len) ? mem[i] : 8'h00;
      exp_q.push_back(b);
      c = ref_crc(c, b);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
  endtask

  // Scoreboard drain against captured bytes starting at base.
  task automatic score(input int base, output int ngot, output int nwant, output int nbad);
    logic [7:0] e;
    ngot = cap_q.size() - base;
    nwant = exp_q.size();
    nbad = 0;
    for (int i = 0; i < nwant; i++) begin
      e = exp_q.pop_front();
      if (i >= ngot) nbad++;
      else if (cap_q[base + i] !== e) nbad++;
    end
  endtask

  task automatic start_frame(input int len);
    @(posedge clk); #1;
    bus.tx_start = 1'b1;
    bus.tx_len = 11'(len);
    start_cyc = cyc;
    @(posedge clk); #1;
    bus.tx_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.tx_done) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.TX_EN !== 1'b0) begin failures++; $display("FAIL rst_tx_en got %b want 0", bus.TX_EN); end
    checks++; if (bus.TXD !== 8'h00) begin failures++; $display("FAIL rst_txd got %h want 00", bus.TXD); end
    checks++; if (bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) begin
      failures++; $display("FAIL rst_busy_done got %b%b want 00", bus.tx_busy, bus.tx_done); end
    checks++; if (bus.tx_rd_en !== 1'b0 || bus.tx_addr !== 11'd0) begin
      failures++; $display("FAIL rst_rd got en=%b addr=%0d want 0/0", bus.tx_rd_en, bus.tx_addr); end
    checks++; if (bus.TX_ER !== 1'b0) begin failures++; $display("FAIL rst_tx_er got %b want 0", bus.TX_ER); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_crc_unit();
    string s;
    s = "123456789";
    @(posedge clk); #1;
    c_init = 1'b1;
    @(posedge clk); #1;
    c_init = 1'b0;
    c_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      c_data = s[i];
      @(posedge clk); #1;
    end
    c_en = 1'b0;
    checks++; if (~c_crc !== 32'hCBF43926) begin
      failures++; $display("FAIL crc_check got %h want cbf43926", ~c_crc); end
  endtask

  task automatic test_frame64();
    int base, en0, rd0, done0, er0, ngot, nwant, nbad;
    bit ok;
    logic [31:0] c;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    base = cap_q.size(); en0 = en_cnt; rd0 = rd_cnt; done0 = done_cnt; er0 = er_cnt;
    push_expected(64);
    start_frame(64);
    checks++; if (bus.tx_busy !== 1'b1 || bus.TX_EN !== 1'b1 || bus.TXD !== 8'h55) begin
      failures++; $display("FAIL f64_cycle1 got busy=%b en=%b txd=%h want 1/1/55",
                           bus.tx_busy, bus.TX_EN, bus.TXD); end
    wait_done(300, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL f64_done_timeout got 0 want 1"); end
    c = 32'hFFFFFFFF;
    for (int i = base + 8; i < cap_q.size(); i++) c = ref_crc(c, cap_q[i]);
    score(base, ngot, nwant, nbad);
    checks++; if (ngot !== nwant || nbad !== 0) begin
      failures++; $display("FAIL f64_bytes got %0d bytes (%0d bad) want %0d bytes", ngot, nbad, nwant); end
    checks++; if (c !== CRC_RESIDUE) begin failures++; $display("FAIL f64_residue got %h want debb20e3", c); end
    checks++; if (en_cnt - en0 !== 76) begin failures++; $display("FAIL f64_tx_en got %0d want 76", en_cnt - en0); end
    checks++; if (rd_cnt - rd0 !== 64) begin failures++; $display("FAIL f64_rd_en got %0d want 64", rd_cnt - rd0); end
    checks++; if (rd_rise_q.size() == 0 || rd_rise_q[$] - start_cyc !== 7) begin
      failures++; $display("FAIL f64_prefetch got cycle %0d want 7",
                           rd_rise_q.size() == 0 ? -1 : rd_rise_q[$] - start_cyc); end
    checks++; if (done_cnt - done0 !== 1 || done_cyc - last_en_cyc !== 12) begin
      failures++; $display("FAIL f64_done got n=%0d dist=%0d want 1/12",
                           done_cnt - done0, done_cyc - last_en_cyc); end
    checks++; if (er_cnt - er0 !== 0) begin failures++; $display("FAIL f64_tx_er got %0d want 0", er_cnt - er0); end
  endtask

  task automatic test_short();
    int base, en0, rd0, done0, ngot, nwant, nbad;
    bit ok;
    for (int i = 0; i < 14; i++) mem[i] = 8'($urandom_range(0, 255));
    for (int i = 14; i < 64; i++) mem[i] = 8'hA5;
    base = cap_q.size(); en0 = en_cnt; rd0 = rd_cnt; done0 = done_cnt;
    push_expected(14);
    start_frame(14);
    wait_done(300, ok);
    score(base, ngot, nwant, nbad);
    checks++; if (ok !== 1'b1 || ngot !== nwant || nbad !== 0) begin
      failures++; $display("FAIL pad_bytes got ok=%0d %0d bytes (%0d bad) want 1/%0d/0", ok, ngot, nbad, nwant); end
    checks++; if (en_cnt - en0 !== 72) begin failures++; $display("FAIL pad_tx_en got %0d want 72", en_cnt - en0); end
    checks++; if (rd_cnt - rd0 !== 14) begin failures++; $display("FAIL pad_rd_en got %0d want 14", rd_cnt - rd0); end
    checks++; if (done_cnt - done0 !== 1) begin failures++; $display("FAIL pad_done got %0d want 1", done_cnt - done0); end
  endtask

  task automatic test_back_to_back();
    int base, en0, rise0, done0, ngot, nwant, nbad;
    bit ok1, ok2;
    for (int i = 0; i < 60; i++) mem[i] = 8'($urandom_range(0, 255));
    base = cap_q.size(); en0 = en_cnt; rise0 = rise_q.size(); done0 = done_cnt;
    push_expected(60);
    push_expected(60);
    @(posedge clk); #1;
    bus.tx_start = 1'b1;
    bus.tx_len = 11'd60;
    // Start stays high through frame 1; the done-cycle start launches frame 2.
    ok1 = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.tx_done) begin ok1 = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.tx_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      bus.tx_start = ~bus.tx_start;
    end
    bus.tx_start = 1'b0;
    wait_done(300, ok2);
    repeat (20) @(posedge clk);
    #1;
    score(base, ngot, nwant, nbad);
    checks++; if (ok1 !== 1'b1 || ok2 !== 1'b1) begin
      failures++; $display("FAIL b2b_timeout got %0d%0d want 11", ok1, ok2); end
    checks++; if (ngot !== nwant || nbad !== 0) begin
      failures++; $display("FAIL b2b_bytes got %0d bytes (%0d bad) want %0d", ngot, nbad, nwant); end
    checks++; if (rise_q.size() - rise0 !== 2 || en_cnt - en0 !== 144) begin
      failures++; $display("FAIL b2b_frames got %0d frames %0d en want 2/144",
                           rise_q.size() - rise0, en_cnt - en0); end
    checks++; if (gap !== 12) begin failures++; $display("FAIL b2b_gap got %0d want 12", gap); end
    checks++; if (done_cnt - done0 !== 2) begin failures++; $display("FAIL b2b_done got %0d want 2", done_cnt - done0); end
  endtask

  task automatic test_invalid();
    int en0, busy0, done0;
    en0 = en_cnt; busy0 = busy_cnt; done0 = done_cnt;
    start_frame(0);
    repeat (5) @(posedge clk);
    start_frame(1515);
    repeat (30) @(posedge clk);
    #1;
    checks++; if (en_cnt - en0 !== 0) begin failures++; $display("FAIL inv_tx_en got %0d want 0", en_cnt - en0); end
    checks++; if (busy_cnt - busy0 !== 0) begin failures++; $display("FAIL inv_busy got %0d want 0", busy_cnt - busy0); end
    checks++; if (done_cnt - done0 !== 0) begin failures++; $display("FAIL inv_done got %0d want 0", done_cnt - done0); end
  endtask

  task automatic test_reset_mid();
    int base, done0, ngot, nwant, nbad;
    bit ok;
    for (int i = 0; i < 100; i++) mem[i] = 8'(i * 3 + 7);
    done0 = done_cnt;
    start_frame(100);
    repeat (28) @(posedge clk);
    #1;
    checks++; if (bus.TX_EN !== 1'b1 || bus.TXD !== mem[20]) begin
      failures++; $display("FAIL mid_byte20 got en=%b txd=%h want 1/%h", bus.TX_EN, bus.TXD, mem[20]); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.TX_EN !== 1'b0 || bus.TXD !== 8'h00 || bus.tx_busy !== 1'b0 || bus.tx_rd_en !== 1'b0) begin
      failures++; $display("FAIL mid_reset got en=%b txd=%h busy=%b rd=%b want 0/00/0/0",
                           bus.TX_EN, bus.TXD, bus.tx_busy, bus.tx_rd_en); end
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checks++; if (done_cnt - done0 !== 0) begin failures++; $display("FAIL mid_no_done got %0d want 0", done_cnt - done0); end
    base = cap_q.size();
    push_expected(100);
    start_frame(100);
    wait_done(400, ok);
    score(base, ngot, nwant, nbad);
    checks++; if (ok !== 1'b1 || ngot !== nwant || nbad !== 0) begin
      failures++; $display("FAIL mid_refresh got ok=%0d %0d bytes (%0d bad) want 1/%0d/0", ok, ngot, nbad, nwant); end
  endtask

  initial begin
    bus.tx_start = 1'b0;
    bus.tx_len = 11'd0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    test_reset();
    test_crc_unit();
    test_frame64();
    test_short();
    test_back_to_back();
    test_invalid();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
